// File: rtl/centroid_pkg.sv
// Shared constants, RGB444 layout and FSM encoding for the colour-blob locator.
// The optional filtered-pixel output is enabled by CENTROID_FILTOUT_EN.
package centroid_pkg;

   localparam int C_NUM_BANDS    = 8;
   localparam int C_NB_BAND_CNT  = 12;
   localparam int C_NB_TOTAL_CNT = 15;
   localparam int C_NB_CH        = 4;
   localparam int C_NB_RGB       = 3 * C_NB_CH;
   localparam int C_BAND_COLS    = 20;
   localparam int C_IMG_ROWS     = 120;
   localparam int C_PROX_SHIFT   = 11;

   localparam logic [7:0]               C_IMG_COLS = 8'd160;
   localparam logic [C_NB_CH-1:0]       C_THR_ON   = 4'd8;
   localparam logic [C_NB_CH-1:0]       C_THR_OFF  = 4'd6;
   localparam logic [C_NB_BAND_CNT-1:0] C_MIN_PXLS = 12'd32;

   typedef struct packed {
      logic [C_NB_CH-1:0] r;
      logic [C_NB_CH-1:0] g;
      logic [C_NB_CH-1:0] b;
   } rgb444_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SCAN,
      UPDATE
   } state_t;

   // Compare chain against band edges; avoids a divide by 20.
   function automatic logic [2:0] band_of(input logic [7:0] col);
      logic [2:0] b;
      b = '0;
      for (int i = 1; i < C_NUM_BANDS; i++)
         if (col >= 8'(i * C_BAND_COLS))
            b = 3'(i);
      return b;
   endfunction

endpackage

// File: rtl/color_pxl_filter.sv
// Stage 1: registered colour-match flag and band index for each pixel.
// With CENTROID_FILTOUT_EN it also registers the masked pixel stream.
module color_pxl_filter
   import centroid_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                pxl_valid,
   input  logic [7:0]          pxl_col,
   input  logic [C_NB_RGB-1:0] pxl_rgb,
   input  logic [2:0]          rgbfilter,
   output logic                match,
   output logic [2:0]          band,
   output logic                filt_valid,
   output logic [C_NB_RGB-1:0] filt_pxl
);

   rgb444_t px;
   logic    ok_r, ok_g, ok_b;
   logic    match_c;

   assign px   = rgb444_t'(pxl_rgb);
   assign ok_r = rgbfilter[2] ? (px.r >= C_THR_ON) : (px.r < C_THR_OFF);
   assign ok_g = rgbfilter[1] ? (px.g >= C_THR_ON) : (px.g < C_THR_OFF);
   assign ok_b = rgbfilter[0] ? (px.b >= C_THR_ON) : (px.b < C_THR_OFF);

   assign match_c = pxl_valid && (rgbfilter != 3'b000) &&
                    (pxl_col < C_IMG_COLS) && ok_r && ok_g && ok_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match <= 1'b0;
         band  <= '0;
      end else begin
         match <= match_c;
         band  <= band_of(pxl_col);
      end
   end

`ifdef CENTROID_FILTOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_valid <= 1'b0;
         filt_pxl   <= '0;
      end else begin
         filt_valid <= pxl_valid;
         filt_pxl   <= match_c ? pxl_rgb : '0;
      end
   end
`else
   assign filt_valid = 1'b0;
   assign filt_pxl   = '0;
`endif

endmodule

// File: rtl/color_centroid.sv
// Per-frame colour-blob locator: band histogram, max-band scan, proximity.
// CENTROID_FILTOUT_EN enables the filt_valid/filt_pxl mask stream.
module color_centroid
   import centroid_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
   input  logic                pxl_valid,
   input  logic [7:0]          pxl_col,
   input  logic [C_NB_RGB-1:0] pxl_rgb,
   input  logic [2:0]          rgbfilter,
   output logic [7:0]          centroid,
   output logic [2:0]          proximity,
   output logic                frame_done,
   output logic                filt_valid,
   output logic [C_NB_RGB-1:0] filt_pxl
);

   logic                      s1_match;
   logic [2:0]                s1_band;
   logic                      fs_d1, fs_d2;
   logic [C_NB_BAND_CNT-1:0]  band_cnt [C_NUM_BANDS];
   logic [C_NB_BAND_CNT-1:0]  band_shd [C_NUM_BANDS];
   logic [C_NB_TOTAL_CNT-1:0] total_cnt, total_shd;
   state_t                    state, state_nx;
   logic [2:0]                scan_idx, max_idx;
   logic [C_NB_BAND_CNT-1:0]  max_cnt;
   logic                      snap;
   logic [3:0]                prox_raw;

   color_pxl_filter u_filter (
      .clk        (clk),
      .rst        (rst),
      .pxl_valid  (pxl_valid),
      .pxl_col    (pxl_col),
      .pxl_rgb    (pxl_rgb),
      .rgbfilter  (rgbfilter),
      .match      (s1_match),
      .band       (s1_band),
      .filt_valid (filt_valid),
      .filt_pxl   (filt_pxl)
   );

   assign snap     = (state == ACCUM) && fs_d2;
   assign prox_raw = 4'(total_shd >> C_PROX_SHIFT);

   // Two-cycle delay lets pixels already in the pipe land in their own frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fs_d1 <= 1'b0;
         fs_d2 <= 1'b0;
      end else begin
         fs_d1 <= frame_start;
         fs_d2 <= fs_d1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < C_NUM_BANDS; b++)
            band_cnt[b] <= '0;
         total_cnt <= '0;
      end else begin
         for (int b = 0; b < C_NUM_BANDS; b++) begin
            if (fs_d2)
               band_cnt[b] <= C_NB_BAND_CNT'(s1_match && (s1_band == 3'(b)));
            else if (s1_match && (s1_band == 3'(b)) && (band_cnt[b] != '1))
               band_cnt[b] <= band_cnt[b] + C_NB_BAND_CNT'(1);
         end
         if (fs_d2)
            total_cnt <= C_NB_TOTAL_CNT'(s1_match);
         else if (s1_match && (total_cnt != '1))
            total_cnt <= total_cnt + C_NB_TOTAL_CNT'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < C_NUM_BANDS; b++)
            band_shd[b] <= '0;
         total_shd <= '0;
      end else if (snap) begin
         for (int b = 0; b < C_NUM_BANDS; b++)
            band_shd[b] <= band_cnt[b];
         total_shd <= total_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (fs_d2) state_nx = ACCUM;
         ACCUM:   if (fs_d2) state_nx = SCAN;
         SCAN:    if (scan_idx == 3'd7) state_nx = UPDATE;
         UPDATE:  state_nx = ACCUM;
         default: state_nx = IDLE;
      endcase
   end

   // Strict '>' keeps the lowest band on ties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_idx   <= '0;
         max_idx    <= '0;
         max_cnt    <= '0;
         centroid   <= '0;
         proximity  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (snap) begin
            scan_idx <= '0;
            max_idx  <= '0;
            max_cnt  <= '0;
         end else if (state == SCAN) begin
            scan_idx <= scan_idx + 3'd1;
            if (band_shd[scan_idx] > max_cnt) begin
               max_cnt <= band_shd[scan_idx];
               max_idx <= scan_idx;
            end
         end else if (state == UPDATE) begin
            centroid   <= (max_cnt >= C_MIN_PXLS) ? (8'd1 << max_idx) : 8'd0;
            proximity  <= (prox_raw > 4'd7) ? 3'd7 : prox_raw[2:0];
            frame_done <= 1'b1;
         end
      end
   end

endmodule

// File: doc/color_centroid.md
Name: color_centroid

Overview:
- Per-frame colour-blob locator between the OV7670 capture stage and the VGA display stage.
- Each QQVGA pixel from capture is classified against the colour selected by rgbfilter.
- Matching pixels are counted in 8 vertical bands of 20 columns each.
- At each frame boundary, publishes a one-hot centroid band (8 bits) and a 3-bit proximity level; the display stage draws both as bars.

Parameters:
- C_IMG_COLS, 160, image width in pixels.
- C_IMG_ROWS, 120, image height in pixels.
- C_BAND_COLS, 20, columns per band (C_IMG_COLS/8).
- C_THR_ON, 8, 4-bit level a selected channel must reach (>=).
- C_THR_OFF, 6, 4-bit level an unselected channel must stay below (<).
- C_MIN_PXLS, 32, minimum winning-band count for a valid centroid.
- C_PROX_SHIFT, 11, right shift applied to total match count to form proximity.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous reset, active high.
- frame_start, in, 1, 1-cycle pulse from capture at start of each frame.
- pxl_valid, in, 1, pixel strobe.
- pxl_col, in, 8, column of current pixel, 0..159.
- pxl_rgb, in, 12, RGB444 pixel, R in [11:8].
- rgbfilter, in, 3, colour select {R,G,B}.
- centroid, out, 8, one-hot winning band; bit0 = cols 0-19.
- proximity, out, 3, quantised total match count, 7 = closest.
- frame_done, out, 1, 1-cycle pulse when centroid/proximity update.
- filt_valid, out, 1, filtered-pixel strobe (optional feature).
- filt_pxl, out, 12, filtered pixel (optional feature).

Behaviour:
- Reset: single clock clk; asynchronous active-high reset rst. All outputs, counters and state clear to 0; state IDLE.
- Match rule: per channel, if rgbfilter bit = 1 the channel must be >= C_THR_ON; if 0 it must be < C_THR_OFF. rgbfilter=000 never matches.
- Pipeline stage 1 (registered): match flag and band index. Band index comes from a compare chain on pxl_col, no divider. pxl_col >= C_IMG_COLS gives no match.
- Pipeline stage 2: band counter (12 bit) and total counter (15 bit) increment. Both saturate at all-ones.
- Internal frame_start is delayed 2 cycles so in-flight pixels are counted into the frame they belong to.
- FSM:
  - IDLE: wait for frame_start, then go to ACCUM. Outputs hold; first frame produces no result.
  - ACCUM: count matches. On delayed frame_start:
    - copy band and total counters to shadow registers;
    - clear live counters in the same cycle (a pixel in stage 2 that cycle is counted into the new frame);
    - go to SCAN.
  - SCAN: 8 cycles. Compare shadow band 0..7 sequentially, keeping max count and its index. Ties go to the lowest index. Then go to UPDATE.
  - UPDATE: 1 cycle.
    - centroid = one-hot(index) if max >= C_MIN_PXLS, else 0.
    - proximity = min(total >> C_PROX_SHIFT, 7).
    - Pulse frame_done; return to ACCUM.
- Accumulation continues through SCAN/UPDATE.
- frame_start arriving in SCAN/UPDATE: live counters clear, scan completes on old shadow, new snapshot not taken.
- rgbfilter changing mid-frame takes effect on the next pixel; no resync.
- Reset mid-SCAN aborts the scan; outputs return to 0.
- Latency: frame_done 12 cycles after frame_start (2 delay + 1 snapshot + 8 scan + 1 update).

Optional Feature:
- Macro CENTROID_FILTOUT_EN.
- Defined: filt_valid = pxl_valid delayed 1 cycle. filt_pxl = pxl_rgb if matched, else 12'h000. This lets the frame buffer store the match mask.
- Undefined: filt_valid and filt_pxl tied to 0, no extra registers.

Decomposition:
- Package centroid_pkg:
  - constants C_NUM_BANDS=8, C_NB_BAND_CNT=12, C_NB_TOTAL_CNT=15;
  - FSM state encoding IDLE/ACCUM/SCAN/UPDATE;
  - RGB444 field widths shared with capture and display.
- Sub-module color_pxl_filter: registered match flag plus band index, stage 1. Instantiated once.

Test Plan:
- rgbfilter=100; frame of all pxl_rgb=12'hF00 → frame_done 12 cycles after next frame_start; centroid=8'h01 (tie, lowest band); total 19200 gives proximity=7 (19200>>11=9, saturated).
- rgbfilter=010; only cols 100-119 green (12'h0F0) on all 120 rows → centroid=8'h20, total=2400, proximity=1.
- rgbfilter=001; 31 blue pixels in band 3 → centroid=8'h00 (below C_MIN_PXLS); 32 pixels → 8'h08.
- Pixel on the last cycle before frame_start, and pxl_col=165 → pixel counted in old frame; col 165 ignored.
- rst asserted during SCAN → centroid=0, proximity=0, no frame_done; the frame after the next frame_start reports correctly.
- With CENTROID_FILTOUT_EN and rgbfilter=100: pxl_rgb=12'hF11 → filt_pxl=12'hF11 one cycle later; pxl_rgb=12'h8F0 → filt_pxl=12'h000.
